fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the FIFO between NUM_REQ requesters using round-robin arbitration.
//  Latches the winner's word and drives fifo_wr_en/fifo_data_in for one cycle.
//  Checks the FIFO's registered wr_ack/overflow response and retries on overflow.
//  After RETRY_MAX failed attempts it drops the word. Sits between client producers and the FIFO write side.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  FIFO_WIDTH  16  data word width, matches FIFO data_in
//  RETRY_MAX   3   write attempts per word before drop (>=1)
// PORTS
//  clk             in   1                   single clock, rising edge
//  rst             in   1                   synchronous, active-high reset
//  req_valid       in   NUM_REQ             per-requester word pending
//  req_data        in   NUM_REQ*FIFO_WIDTH  requester i word at [i*FIFO_WIDTH +: FIFO_WIDTH]
//  req_ready       out  NUM_REQ             1-cycle pulse: word of requester i written
//  req_drop        out  NUM_REQ             1-cycle pulse: word of requester i dropped
//  fifo_wr_en      out  1                   FIFO write enable
//  fifo_data_in    out  FIFO_WIDTH          FIFO write data
//  fifo_full       in   1                   FIFO full flag
//  fifo_wr_ack     in   1                   FIFO registered write acknowledge
//  fifo_overflow   in   1                   FIFO registered overflow flag
//  grant_id        out  $clog2(NUM_REQ)     requester currently owning the port
//  busy            out  1                   high in any state other than IDLE
//  accept_cnt      out  16                  words written, wraps at 2^16
//  drop_cnt        out  8                   words dropped, saturates at 255
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - state=IDLE; RR pointer=0; retry count=0.
//   - All outputs 0.
//   - Any FIFO response arriving after reset is ignored.
//  FSM states:
//   - IDLE: if |req_valid && !fifo_full, pick winner and go to WRITE.
//     - Winner = first valid at or after the RR pointer, wrapping modulo NUM_REQ.
//     - Latch winner's req_data and grant_id; retry count=0.
//   - WRITE: fifo_wr_en=1 (exactly one cycle) with the latched data; go to CHECK.
//   - CHECK: sample fifo_wr_ack/fifo_overflow, which respond to the WRITE cycle.
//     - wr_ack=1: pulse req_ready[grant_id] next cycle; accept_cnt++; pointer=grant_id+1 (wrap); go to IDLE.
//     - Otherwise, overflow or no ack: retry count++.
//       - If retry count reaches RETRY_MAX: pulse req_drop[grant_id]; drop_cnt++ (sat); pointer=grant_id+1; go to IDLE.
//       - Else go to HOLD.
//   - HOLD: wait while fifo_full=1; when fifo_full=0 go to WRITE. Data and grant_id are unchanged.
//  Handshake rules:
//   - A requester keeps req_valid high until its req_ready or req_drop pulse.
//   - Deasserting req_valid mid-transaction has no effect; the latched word completes.
//   - req_ready and req_drop are never both high; at most one bit of each is set per cycle.
//  Timing:
//   - Latency with the FIFO not full: req_valid high in IDLE gives fifo_wr_en 1 cycle later.
//   - req_ready follows fifo_wr_en by 2 cycles. Best-case throughput is 1 word per 3 cycles.
//  Outputs:
//   - fifo_data_in holds the last latched word when fifo_wr_en=0.
//   - grant_id holds its last value in IDLE.
//  Simultaneous events:
//   - fifo_wr_ack and fifo_overflow both high is treated as an ack.
//   - rst takes priority over every transition.
// STRUCTURE
//  fifo_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, WRITE, CHECK, HOLD} arb_state_e.
//   - Default constants for NUM_REQ, FIFO_WIDTH and RETRY_MAX.
//  Sub-module rr_arbiter:
//   - Combinational rotate-priority pick.
//   - Inputs: req vector, pointer. Outputs: grant_onehot, grant_idx, any_grant.
//  Top: FSM, data/id latch, retry count, output pulse registers, counters.
// TESTING
//  1. Single requester: req_valid=4'b0001, data 16'hA5A5, FIFO empty.
//     -> fifo_wr_en 1 cycle with 16'hA5A5, wr_ack, req_ready=4'b0001 once, accept_cnt=1.
//  2. All four valid continuously, FIFO never full.
//     -> grant order 0,1,2,3,0; each req_ready pulses once per round; 3-cycle spacing.
//  3. FIFO full, req_valid=4'b0100 -> no fifo_wr_en, stays IDLE.
//     -> After release: write occurs, grant_id=2.
//  4. Force overflow on every attempt, RETRY_MAX=3.
//     -> Exactly 3 fifo_wr_en pulses, then req_drop=4'b0100; drop_cnt=1; pointer advances to 3.
//  5. Assert rst in CHECK with wr_ack arriving the same cycle.
//     -> No req_ready; all outputs 0; accept_cnt=0; next grant is from requester 0.
//  6. Requester 1 drops req_valid during HOLD.
//     -> Latched word still written; req_ready[1] pulses; no other requester is granted meanwhile.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Contents:
//   arb_state_e     - arbiter FSM state encoding
//   DEF_*           - default parameter values for requester count, word width
//                     and write attempts per word
//   wrap_inc        - increment an index modulo a count (round-robin pointer step)
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_RETRY_MAX  = 3;

    function automatic int wrap_inc(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals of the write arbiter.
// Modports:
//   slave  - the arbiter: reads requests and FIFO responses, drives grants,
//            FIFO write strobe/data, status and counters
//   master - the environment (requesters + FIFO): the opposite directions
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_drop;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;
    logic [15:0]                   accept_cnt;
    logic [7:0]                    drop_cnt;

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output req_ready, req_drop, fifo_wr_en, fifo_data_in, grant_id, busy,
               accept_cnt, drop_cnt
    );

    modport master (
        output req_valid, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  req_ready, req_drop, fifo_wr_en, fifo_data_in, grant_id, busy,
               accept_cnt, drop_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick.
// Ports:
//   req          in   NUM_REQ  request vector
//   ptr          in   IDX_W    highest-priority index this cycle
//   grant_onehot out  NUM_REQ  one-hot winner (zero when no request)
//   grant_idx    out  IDX_W    winner index (zero when no request)
//   any_grant    out  1        at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Walk from the farthest offset back to the pointer so the last hit kept
    // is the first requester at or after the pointer.
    always_comb begin : pick
        int idx;
        idx       = 0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign any_grant = |req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = any_grant && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// The winner's word is latched, written for one cycle, and the FIFO's
// registered response is checked the following cycle; a failed write is
// retried (waiting out fifo_full) up to RETRY_MAX attempts, then dropped.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  fifo_wr_arbiter_if.slave: req_valid/req_data/req_ready/req_drop,
//        fifo_wr_en/fifo_data_in/fifo_full/fifo_wr_ack/fifo_overflow,
//        grant_id, busy, accept_cnt (wrapping), drop_cnt (saturating)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int RETRY_MAX  = DEF_RETRY_MAX
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int RW    = $clog2(RETRY_MAX + 1);

    arb_state_e state_reg, state_next;

    logic [FIFO_WIDTH-1:0] req_words [NUM_REQ];
    logic [NUM_REQ-1:0]    win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;

    logic [FIFO_WIDTH-1:0] data_reg;
    logic [IDX_W-1:0]      grant_reg;
    logic [NUM_REQ-1:0]    grant_oh_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [RW-1:0]         retry_reg;
    logic [NUM_REQ-1:0]    ready_reg;
    logic [NUM_REQ-1:0]    drop_reg;
    logic [15:0]           accept_cnt_reg;
    logic [7:0]            drop_cnt_reg;
    logic                  wr_en;
    logic                  busy;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign req_words[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req          (bus.req_valid),
        .ptr          (ptr_reg),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx),
        .any_grant    (win_any)
    );

    logic start;
    logic ack;
    logic fail;
    logic retry_last;
    logic [IDX_W-1:0] ptr_after;

    assign start      = (state_reg == IDLE) && win_any && !bus.fifo_full;
    // An ack wins even if overflow is raised alongside it.
    assign ack        = bus.fifo_wr_ack;
    assign fail       = bus.fifo_overflow || !bus.fifo_wr_ack;
    assign retry_last = (retry_reg == RW'(RETRY_MAX - 1));
    assign ptr_after  = IDX_W'(wrap_inc(int'(grant_reg), NUM_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = WRITE;
            WRITE: state_next = CHECK;
            CHECK: begin
                if (ack) begin
                    state_next = IDLE;
                end else if (fail) begin
                    state_next = retry_last ? IDLE : HOLD;
                end
            end
            HOLD:  if (!bus.fifo_full) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en = (state_reg == WRITE);
        busy  = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg       <= '0;
            grant_reg      <= '0;
            grant_oh_reg   <= '0;
            ptr_reg        <= '0;
            retry_reg      <= '0;
            ready_reg      <= '0;
            drop_reg       <= '0;
            accept_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            ready_reg <= '0;
            drop_reg  <= '0;
            if (start) begin
                data_reg     <= req_words[win_idx];
                grant_reg    <= win_idx;
                grant_oh_reg <= win_onehot;
                retry_reg    <= '0;
            end
            if (state_reg == CHECK) begin
                if (ack) begin
                    ready_reg      <= grant_oh_reg;
                    accept_cnt_reg <= accept_cnt_reg + 16'd1;
                    ptr_reg        <= ptr_after;
                end else if (fail) begin
                    if (retry_last) begin
                        drop_reg  <= grant_oh_reg;
                        ptr_reg   <= ptr_after;
                        retry_reg <= '0;
                        if (drop_cnt_reg != 8'hFF) begin
                            drop_cnt_reg <= drop_cnt_reg + 8'd1;
                        end
                    end else begin
                        retry_reg <= retry_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready    = ready_reg;
    assign bus.req_drop     = drop_reg;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = data_reg;
    assign bus.grant_id     = grant_reg;
    assign bus.busy         = busy;
    assign bus.accept_cnt   = accept_cnt_reg;
    assign bus.drop_cnt     = drop_cnt_reg;

endmodule
